// File: rtl/i_cache_sa_if.sv
// i_cache_sa_if: fetcher-side and memory-controller-side buses of the instruction cache
interface i_cache_sa_if;
  logic        mc_ins_asked;
  logic [31:0] mc_ins_addr;
  logic        mc_ins_rdy;
  logic [31:0] mc_ins;
  logic [31:0] if_ins_addr;
  logic        if_ins_asked;
  logic        if_ins_rdy;
  logic [31:0] if_ins;
  modport slave (
    output mc_ins_asked, mc_ins_addr, if_ins_rdy, if_ins,
    input  mc_ins_rdy, mc_ins, if_ins_addr, if_ins_asked
  );
  modport master (
    input  mc_ins_asked, mc_ins_addr, if_ins_rdy, if_ins,
    output mc_ins_rdy, mc_ins, if_ins_addr, if_ins_asked
  );
endinterface

// File: rtl/i_cache_sa.sv
// i_cache_sa: set-associative true-LRU instruction cache with line burst fill; ICACHE_STATS_EN adds hit/miss counters
module i_cache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
`ifdef ICACHE_STATS_EN
  i_cache_sa_if.slave bus,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`else
  i_cache_sa_if.slave bus
`endif
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int SB = $clog2(SETS);
  localparam int AB = $clog2(WAYS);
  localparam int TW = 30 - WB - SB;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nx;
  logic [31:0]   data_q  [WAYS][SETS][LINE_WORDS];
  logic [TW-1:0] tag_q   [WAYS][SETS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [AB-1:0] age_q   [SETS][WAYS];
  logic [31:0]   line_q  [LINE_WORDS];
  logic [31:2]   addr_q;
  logic [WB-1:0] cnt_q;
  logic          killed_q;
  logic [SB-1:0] req_set, fill_set, touch_set;
  logic [TW-1:0] req_tag;
  logic [WB-1:0] req_word, fill_word;
  logic [AB-1:0] hit_way, victim, touch_way;
  logic hit, accept, hit_acc, miss_acc, word_acc, last, install;
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.if_ins_addr[1:0];
  assign req_set   = bus.if_ins_addr[SB+WB+1:WB+2];
  assign req_tag   = bus.if_ins_addr[31:SB+WB+2];
  assign req_word  = bus.if_ins_addr[WB+1:2];
  assign fill_set  = addr_q[SB+WB+1:WB+2];
  assign fill_word = addr_q[WB+1:2];
  // tag lookup for the incoming fetch; victim is the lowest invalid way, else the way with age 0 (LRU)
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && tag_q[w][req_set] == req_tag) begin
        hit = 1'b1;
        hit_way = AB'(w);
      end
      if (age_q[fill_set][w] == '0) victim = AB'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) if (!valid_q[fill_set][w]) victim = AB'(w);
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // FSM next state: a miss starts a fill, the last returned word ends it
  always_comb state_nx = !rdy ? state : state == IDLE ? (miss_acc ? FILL : IDLE) : (word_acc && last ? IDLE : FILL);
  // FSM control strobes; a killed fill completes the burst but never installs
  always_comb begin
    accept    = rdy && state == IDLE && bus.if_ins_asked && !bus.if_ins_rdy && !flush;
    hit_acc   = accept && hit;
    miss_acc  = accept && !hit;
    word_acc  = rdy && state == FILL && bus.mc_ins_rdy;
    last      = cnt_q == WB'(LINE_WORDS - 1);
    install   = word_acc && last && !killed_q && !flush;
    touch_set = hit_acc ? req_set : fill_set;
    touch_way = hit_acc ? hit_way : victim;
  end
  // outputs, fill sequencing, valid bits and LRU ages (MRU age is WAYS-1, LRU age is 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mc_ins_asked <= 1'b0;
      bus.mc_ins_addr <= '0;
      bus.if_ins_rdy <= 1'b0;
      bus.if_ins <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      killed_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else if (rdy) begin
      bus.if_ins_rdy <= hit_acc || install;
      if (hit_acc) bus.if_ins <= data_q[hit_way][req_set][req_word];
      if (install) bus.if_ins <= fill_word == cnt_q ? bus.mc_ins : line_q[fill_word];
      if (miss_acc) begin
        addr_q <= bus.if_ins_addr[31:2];
        bus.mc_ins_asked <= 1'b1;
        bus.mc_ins_addr <= {bus.if_ins_addr[31:WB+2], {(WB+2){1'b0}}};
        cnt_q <= '0;
        killed_q <= 1'b0;
      end
      if (word_acc) begin
        cnt_q <= cnt_q + 1'b1;
        bus.mc_ins_asked <= !last;
        if (!last) bus.mc_ins_addr <= bus.mc_ins_addr + 32'd4;
      end
      if (state == FILL && flush) killed_q <= 1'b1;
      if (flush) for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      if (install) valid_q[fill_set][victim] <= 1'b1;
      if (hit_acc || install)
        for (int w = 0; w < WAYS; w++)
          age_q[touch_set][w] <= AB'(w) == touch_way ? AB'(WAYS - 1) :
            age_q[touch_set][w] > age_q[touch_set][touch_way] ? age_q[touch_set][w] - 1'b1 : age_q[touch_set][w];
    end
  end
  // line buffer capture and line install into the victim way
  always_ff @(posedge clk) begin
    if (word_acc) line_q[cnt_q] <= bus.mc_ins;
    if (install) begin
      tag_q[victim][fill_set] <= addr_q[31:SB+WB+2];
      for (int w = 0; w < LINE_WORDS; w++) data_q[victim][fill_set][w] <= WB'(w) == cnt_q ? bus.mc_ins : line_q[w];
    end
  end
`ifdef ICACHE_STATS_EN
  // hit/miss counters count accepted fetches and survive flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else begin
      if (hit_acc) stat_hits <= stat_hits + 32'd1;
      if (miss_acc) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_i_cache_sa.sv
// tb_i_cache_sa: randomized fetch traffic against a recency-list cache model and a hashed memory
module tb_i_cache_sa;
  localparam int WAYS = 2, SETS = 16, LW = 4, WB = 2, SB = 4;
  logic clk = 0, rst = 0, rdy = 1, flush = 0, rdy_s = 0, prev_ifr = 0;
  int checks = 0, errors = 0, cyc = 0, mc_words = 0, done_cyc = -1, fill_start = 0;
  logic [31:0] cur_addr = 0, fill_base = 0;
  logic [31:0] rec [SETS][WAYS];
  int rcnt [SETS];
  i_cache_sa_if bus();
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  i_cache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdy_s <= rdy && !rst;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int s = int'((a >> (2 + WB)) % SETS);
    logic [31:0] t = a >> (2 + WB + SB);
    for (int i = 0; i < rcnt[s]; i++) if (rec[s][i] == t) return i;
    return -1;
  endfunction

  task automatic m_touch(input logic [31:0] a);
    int s = int'((a >> (2 + WB)) % SETS);
    int i = m_find(a);
    if (i < 0) begin
      i = rcnt[s] < WAYS ? rcnt[s] : WAYS - 1;
      if (rcnt[s] < WAYS) rcnt[s]++;
    end
    for (int j = i; j > 0; j--) rec[s][j] = rec[s][j-1];
    rec[s][0] = a >> (2 + WB + SB);
  endtask

  task automatic m_clear();
    foreach (rcnt[s]) rcnt[s] = 0;
  endtask

  always @(negedge clk) begin
    if (bus.mc_ins_rdy) begin
      if (rdy_s) begin
        mc_words++;
        done_cyc = cyc;
      end
      bus.mc_ins_rdy = 0;
    end else if (bus.mc_ins_asked && $urandom_range(2) != 0) begin
      chk("mc_addr", bus.mc_ins_addr, fill_base + 32'(4 * ((mc_words - fill_start) % LW)));
      bus.mc_ins_rdy = 1;
      bus.mc_ins = mem(bus.mc_ins_addr);
    end
  end

  always @(negedge clk) begin
    if (!rst && rdy_s && bus.if_ins_rdy) chk("if_ins", bus.if_ins, mem(cur_addr));
    if (!rst && rdy_s && prev_ifr) chk("if_rdy_pulse", 32'(bus.if_ins_rdy), 0);
    prev_ifr = bus.if_ins_rdy;
  end

  task automatic start_fetch(input logic [31:0] a, input int lit, input bit fl, output bit exp_hit);
    @(negedge clk);
    if (fl) m_clear();
    exp_hit = m_find(a) >= 0;
    if (lit != 2) chk("model_pin", 32'(exp_hit), 32'(lit));
    cur_addr = a;
    fill_base = a & ~32'(LW * 4 - 1);
    fill_start = mc_words;
    bus.if_ins_addr = a;
    bus.if_ins_asked = 1;
    flush = fl;
    if (fl) begin
      @(negedge clk);
      flush = 0;
    end
  endtask

  task automatic finish_fetch(input bit exp_hit, input bit lat);
    int n = 0;
    while (!bus.if_ins_rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("fetch_done", 32'(bus.if_ins_rdy), 1);
    chk("fill_words", 32'(mc_words - fill_start), exp_hit ? 0 : LW);
    if (exp_hit && lat) chk("hit_latency", 32'(n), 1);
    if (!exp_hit) chk("miss_latency", 32'(done_cyc), 32'(cyc));
    bus.if_ins_asked = 0;
    m_touch(cur_addr);
  endtask

  task automatic fetch(input logic [31:0] a, input int lit, input bit fl);
    bit h;
    start_fetch(a, lit, fl, h);
    finish_fetch(h, !fl);
  endtask

  task automatic wait_first_word();
    int n = 0;
    while (mc_words - fill_start < 1 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("first_word", 32'(mc_words - fill_start), 1);
  endtask

  initial begin
    bit h, seen;
    int n;
    logic [31:0] a;
    bus.if_ins_asked = 0;
    bus.if_ins_addr = 0;
    bus.mc_ins_rdy = 0;
    bus.mc_ins = 0;
    m_clear();
    #1 rst = 1;
    #1;
    chk("rst_mc_asked", 32'(bus.mc_ins_asked), 0);
    chk("rst_mc_addr", bus.mc_ins_addr, 0);
    chk("rst_if_rdy", 32'(bus.if_ins_rdy), 0);
    chk("rst_if_ins", bus.if_ins, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    fetch(32'h1000, 0, 0);
    chk("lit_word0", bus.if_ins, 32'h2DC10234);
    fetch(32'h1008, 1, 0);
    chk("lit_word2", bus.if_ins, 32'h330CCFBC);
    fetch(32'h2000, 0, 0);
    fetch(32'h1000, 1, 0);
    fetch(32'h3000, 0, 0);
    fetch(32'h1000, 1, 0);
    fetch(32'h2000, 0, 0);
    start_fetch(32'h4000, 0, 0, h);
    wait_first_word();
    flush = 1;
    m_clear();
    @(negedge clk);
    flush = 0;
    seen = 0;
    n = 0;
    while (mc_words - fill_start < LW && n < 400) begin
      @(negedge clk);
      #1;
      seen |= bus.if_ins_rdy;
      n++;
    end
    bus.if_ins_asked = 0;
    chk("kill_words", 32'(mc_words - fill_start), LW);
    repeat (3) begin
      @(negedge clk);
      #1;
      seen |= bus.if_ins_rdy;
    end
    chk("kill_no_rdy", 32'(seen), 0);
    chk("kill_idle", 32'(bus.mc_ins_asked), 0);
    fetch(32'h4000, 0, 0);
    start_fetch(32'h6000, 0, 0, h);
    wait_first_word();
    rdy = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("frz_addr", bus.mc_ins_addr, fill_base + 4);
      chk("frz_asked", 32'(bus.mc_ins_asked), 1);
      chk("frz_if_rdy", 32'(bus.if_ins_rdy), 0);
      chk("frz_words", 32'(mc_words - fill_start), 1);
    end
    rdy = 1;
    finish_fetch(h, 0);
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(19) == 0) begin
        @(negedge clk);
        flush = 1;
        m_clear();
        @(negedge clk);
        flush = 0;
      end
      a = ($urandom_range(4) << 8) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2);
      fetch(a, 2, $urandom_range(14) == 0);
    end
    fetch(32'h1000, 2, 0);
    fetch(32'h1000, 1, 0);
    start_fetch(32'h5000, 2, 0, h);
    wait_first_word();
    #2 rst = 1;
    #1;
    chk("rstfill_mc_asked", 32'(bus.mc_ins_asked), 0);
    chk("rstfill_mc_addr", bus.mc_ins_addr, 0);
    chk("rstfill_if_rdy", 32'(bus.if_ins_rdy), 0);
    chk("rstfill_if_ins", bus.if_ins, 0);
    bus.if_ins_asked = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_clear();
    fetch(32'h1000, 0, 0);
    fetch(32'h2000, 0, 0);
    fetch(32'h1000, 1, 0);
`ifdef ICACHE_STATS_EN
    chk("stat_misses", stat_misses, 2);
    chk("stat_hits", stat_hits, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
